// File: rtl/mag_sq_feeder_pkg.sv
// mag_sq_pkg: shared FSM state type and sqrt-interface widths for the magnitude-squared feeder
package mag_sq_pkg;
  typedef enum logic [2:0] {IDLE, SQ_RE, SQ_IM, SCALE, ISSUE, WAIT_DONE} state_t;
  localparam int SQ_W = 8;
  localparam int ROOT_W = 4;
  localparam int SAT_MAX = 255;
endpackage

// File: rtl/mag_sq_feeder_if.sv
// mag_sq_feeder_if: bin input handshake, sqrt go/done link and tagged magnitude output; master=upstream/sqrt side, slave=feeder
interface mag_sq_feeder_if #(parameter int IN_W = 8, parameter int IDX_W = 7);
  import mag_sq_pkg::*;
  logic in_valid;
  logic in_ready;
  logic signed [IN_W-1:0] in_re;
  logic signed [IN_W-1:0] in_im;
  logic [IDX_W-1:0] in_idx;
  logic sq_go;
  logic [SQ_W-1:0] sq_sw;
  logic sq_done;
  logic [ROOT_W-1:0] sq_root;
  logic mag_valid;
  logic [ROOT_W-1:0] mag_out;
  logic [IDX_W-1:0] mag_idx;
  modport master(output in_valid, in_re, in_im, in_idx, sq_done, sq_root, input in_ready, sq_go, sq_sw, mag_valid, mag_out, mag_idx);
  modport slave(input in_valid, in_re, in_im, in_idx, sq_done, sq_root, output in_ready, sq_go, sq_sw, mag_valid, mag_out, mag_idx);
endinterface

// File: rtl/mag_sq_feeder_sq.sv
// sq_shift_add: serial unsigned squarer, one multiplier bit per cycle over IN_W cycles; i_start cycle performs step 0 from i_a/i_acc, o_done marks the last step
module sq_shift_add #(
  parameter int IN_W = 8,
  localparam int AW = 2 * IN_W + 1,
  localparam int CW = $clog2(IN_W + 1)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            i_start,
  input  logic [IN_W-1:0] i_a,
  input  logic [AW-1:0]   i_acc,
  output logic [AW-1:0]   o_acc,
  output logic            o_busy,
  output logic            o_done
);
  logic [IN_W-1:0] r_a, r_b, w_a, w_b;
  logic [CW-1:0] r_cnt, w_k;
  logic [AW-1:0] r_acc, w_base, w_add;
  logic r_busy, w_en;
  always_comb begin
    w_a = i_start ? i_a : r_a;
    w_b = i_start ? i_a : r_b;
    w_k = i_start ? '0 : r_cnt;
    w_base = i_start ? i_acc : r_acc;
    w_add = w_b[0] ? (AW'(w_a) << w_k) : '0;
  end
  assign w_en = i_start | r_busy;
  assign o_done = w_en & (w_k == CW'(IN_W - 1));
  assign o_busy = r_busy;
  assign o_acc = r_acc;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_acc <= '0;
    end else if (w_en) begin
      r_a <= w_a;
      r_b <= w_b >> 1;
      r_cnt <= w_k + 1'b1;
      r_busy <= ~o_done;
      r_acc <= w_base + w_add;
    end
endmodule

// File: rtl/mag_sq_feeder.sv
// mag_sq_feeder: re^2+im^2 via one reused serial squarer, scaled/saturated to 8 bits, handed to sqrt (go/done), 4-bit magnitude returned with bin tag; ports clk, clr_n, bus (slave)
module mag_sq_feeder import mag_sq_pkg::*; #(
  parameter int IN_W = 8,
  parameter int SHIFT = 7,
  parameter int IDX_W = 7
) (
  input logic clk,
  input logic clr_n,
  mag_sq_feeder_if.slave bus
);
  localparam int AW = 2 * IN_W + 1;
  state_t r_state;
  logic [IN_W-1:0] r_re, r_im, w_abs_re, w_abs_im, w_a;
  logic [IDX_W-1:0] r_idx;
  logic [AW-1:0] w_acc, w_acc_in, w_sh;
  logic [SQ_W-1:0] w_sat;
  logic w_start, w_busy, w_done;
  always_comb begin
    w_abs_re = bus.in_re[IN_W-1] ? IN_W'(-bus.in_re) : IN_W'(bus.in_re);
    w_abs_im = bus.in_im[IN_W-1] ? IN_W'(-bus.in_im) : IN_W'(bus.in_im);
    w_start = (r_state == SQ_RE || r_state == SQ_IM) && !w_busy;
    w_a = (r_state == SQ_RE) ? r_re : r_im;
    w_acc_in = (r_state == SQ_RE) ? '0 : w_acc;
    w_sh = w_acc >> SHIFT;
    w_sat = (w_sh > AW'(SAT_MAX)) ? SQ_W'(SAT_MAX) : w_sh[SQ_W-1:0];
  end
  sq_shift_add #(.IN_W(IN_W)) u_sq (
    .clk(clk), .clr_n(clr_n), .i_start(w_start), .i_a(w_a), .i_acc(w_acc_in),
    .o_acc(w_acc), .o_busy(w_busy), .o_done(w_done)
  );
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state <= IDLE;
      r_re <= '0;
      r_im <= '0;
      r_idx <= '0;
      bus.in_ready <= 1'b1;
      bus.sq_go <= 1'b0;
      bus.sq_sw <= '0;
      bus.mag_valid <= 1'b0;
      bus.mag_out <= '0;
      bus.mag_idx <= '0;
    end else begin
      bus.mag_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_re <= w_abs_re;
          r_im <= w_abs_im;
          r_idx <= bus.in_idx;
          bus.in_ready <= 1'b0;
          r_state <= SQ_RE;
        end
        SQ_RE: if (w_done) r_state <= SQ_IM;
        SQ_IM: if (w_done) r_state <= SCALE;
        SCALE: begin
          bus.sq_sw <= w_sat;
          bus.sq_go <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          bus.sq_go <= 1'b0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: if (bus.sq_done) begin
          bus.mag_out <= bus.sq_root;
          bus.mag_idx <= r_idx;
          bus.mag_valid <= 1'b1;
          bus.in_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mag_sq_feeder.sv
// tb_mag_sq_feeder: randomized and directed checks of two feeder instances (SHIFT=7, SHIFT=0) against an arithmetic model and a behavioural sqrt responder
module tb_mag_sq_feeder;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rc_a = 0, rc_b = 0;
  logic rd_a = 1'b0, rd_b = 1'b0;
  bit hold_a = 1'b0, mute_a = 1'b0;
  int mq_a[$];
  int mq_b[$];
  int go_cyc_a = 0, go_sw_a = 0, go_n_a = 0, strobe_cyc_a = 0;
  int go_sw_b = 0;
  mag_sq_feeder_if #(.IN_W(8), .IDX_W(7)) a_if ();
  mag_sq_feeder_if #(.IN_W(8), .IDX_W(7)) b_if ();
  mag_sq_feeder #(.IN_W(8), .SHIFT(7), .IDX_W(7)) ua (.clk(clk), .clr_n(clr_n), .bus(a_if));
  mag_sq_feeder #(.IN_W(8), .SHIFT(0), .IDX_W(7)) ub (.clk(clk), .clr_n(clr_n), .bus(b_if));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int isqrt(input int v);
    for (int r = 15; r >= 0; r--) if (r * r <= v) return r;
    return 0;
  endfunction
  function automatic int exp_sw(input int re, input int im, input int sh);
    int s;
    s = (re * re + im * im) >>> sh;
    return s > 255 ? 255 : s;
  endfunction
  assign a_if.sq_done = rd_a | hold_a;
  assign a_if.sq_root = 4'(isqrt(int'(a_if.sq_sw)));
  assign b_if.sq_done = rd_b;
  assign b_if.sq_root = 4'(isqrt(int'(b_if.sq_sw)));
  always @(negedge clk or negedge clr_n)
    if (!clr_n) begin
      rc_a = 0;
      rd_a = 1'b0;
    end else begin
      rd_a = 1'b0;
      if (rc_a > 0) begin
        rc_a--;
        if (rc_a == 0) rd_a = 1'b1;
      end
      if (a_if.sq_go && !mute_a) rc_a = 3;
    end
  always @(negedge clk or negedge clr_n)
    if (!clr_n) begin
      rc_b = 0;
      rd_b = 1'b0;
    end else begin
      rd_b = 1'b0;
      if (rc_b > 0) begin
        rc_b--;
        if (rc_b == 0) rd_b = 1'b1;
      end
      if (b_if.sq_go) rc_b = 3;
    end
  always @(negedge clk)
    if (clr_n) begin
      if (a_if.mag_valid) begin
        mq_a.push_back(int'(a_if.mag_idx) * 16 + int'(a_if.mag_out));
        strobe_cyc_a = cyc;
      end
      if (a_if.sq_go) begin
        go_cyc_a = cyc;
        go_sw_a = int'(a_if.sq_sw);
        go_n_a++;
      end
      if (b_if.mag_valid) mq_b.push_back(int'(b_if.mag_idx) * 16 + int'(b_if.mag_out));
      if (b_if.sq_go) go_sw_b = int'(b_if.sq_sw);
    end
  task automatic push(input int u, input int re, input int im, input int idx, output int c0);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (u == 0) begin
      a_if.in_valid = 1'b1; a_if.in_re = 8'(re); a_if.in_im = 8'(im); a_if.in_idx = 7'(idx);
    end else begin
      b_if.in_valid = 1'b1; b_if.in_re = 8'(re); b_if.in_im = 8'(im); b_if.in_idx = 7'(idx);
    end
    for (int k = 0; k < 200; k++) begin
      if ((u == 0) ? a_if.in_ready : b_if.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout unit=%0d got no in_ready want in_ready", u);
    end
    @(posedge clk);
    #1 c0 = cyc;
    if (u == 0) a_if.in_valid = 1'b0; else b_if.in_valid = 1'b0;
  endtask
  task automatic wait_mag(input int u, input int n);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (((u == 0) ? mq_a.size() : mq_b.size()) >= n) return;
    end
    total++; bad++;
    $display("FAIL strobe_timeout unit=%0d got %0d strobes want %0d", u, (u == 0) ? mq_a.size() : mq_b.size(), n);
  endtask
  task automatic test_reset;
    a_if.in_valid = 1'b0; a_if.in_re = '0; a_if.in_im = '0; a_if.in_idx = '0;
    b_if.in_valid = 1'b0; b_if.in_re = '0; b_if.in_im = '0; b_if.in_idx = '0;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (a_if.sq_go !== 1'b0) begin bad++; $display("FAIL rst_sq_go got %0b want 0", a_if.sq_go); end
    total++; if (a_if.sq_sw !== 8'd0) begin bad++; $display("FAIL rst_sq_sw got %0d want 0", a_if.sq_sw); end
    total++; if (a_if.mag_valid !== 1'b0) begin bad++; $display("FAIL rst_mag_valid got %0b want 0", a_if.mag_valid); end
    total++; if (a_if.mag_out !== 4'd0) begin bad++; $display("FAIL rst_mag_out got %0d want 0", a_if.mag_out); end
    total++; if (a_if.mag_idx !== 7'd0) begin bad++; $display("FAIL rst_mag_idx got %0d want 0", a_if.mag_idx); end
    clr_n = 1'b1;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_a got %0b want 1", a_if.in_ready); end
    total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_b got %0b want 1", b_if.in_ready); end
  endtask
  task automatic test_basic;
    int c0, rdy_hi;
    mq_a.delete(); go_n_a = 0; rdy_hi = 0;
    push(0, 100, 50, 5, c0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (mq_a.size() > 0) break;
      if (a_if.in_ready) rdy_hi++;
    end
    total++; if (mq_a.size() != 1) begin bad++; $display("FAIL basic_strobe got %0d strobes want 1", mq_a.size()); end
    total++; if (go_cyc_a - c0 != 17) begin bad++; $display("FAIL basic_go_delay got %0d want 17", go_cyc_a - c0); end
    total++; if (go_n_a != 1) begin bad++; $display("FAIL basic_go_pulses got %0d want 1", go_n_a); end
    total++; if (go_sw_a != 97) begin bad++; $display("FAIL basic_sq_sw got %0d want 97", go_sw_a); end
    total++; if (mq_a.size() == 0 || mq_a[0] != 5 * 16 + 9) begin bad++; $display("FAIL basic_mag got %0d want %0d", mq_a.size() ? mq_a[0] : -1, 5 * 16 + 9); end
    total++; if (strobe_cyc_a - c0 != 21) begin bad++; $display("FAIL basic_latency got %0d want 21", strobe_cyc_a - c0); end
    total++; if (rdy_hi != 0) begin bad++; $display("FAIL basic_ready_busy got %0d high cycles want 0", rdy_hi); end
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_with_valid got %0b want 1", a_if.in_ready); end
    @(negedge clk);
    total++; if (a_if.mag_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got %0b want 0", a_if.mag_valid); end
    total++; if (a_if.mag_out !== 4'd9 || a_if.mag_idx !== 7'd5) begin bad++; $display("FAIL basic_hold got %0d/%0d want 9/5", a_if.mag_out, a_if.mag_idx); end
  endtask
  task automatic test_sat;
    int c0;
    mq_a.delete();
    push(0, -128, -128, 77, c0);
    wait_mag(0, 1);
    total++; if (go_sw_a != 255) begin bad++; $display("FAIL sat_sq_sw got %0d want 255", go_sw_a); end
    total++; if (mq_a.size() == 0 || mq_a[0] != 77 * 16 + 15) begin bad++; $display("FAIL sat_mag got %0d want %0d", mq_a.size() ? mq_a[0] : -1, 77 * 16 + 15); end
  endtask
  task automatic test_shift0;
    int c0;
    mq_b.delete();
    push(1, 8, 0, 1, c0);
    wait_mag(1, 1);
    total++; if (go_sw_b != 64) begin bad++; $display("FAIL shift0_sw_64 got %0d want 64", go_sw_b); end
    total++; if (mq_b.size() < 1 || mq_b[0] != 1 * 16 + 8) begin bad++; $display("FAIL shift0_mag_8 got %0d want %0d", mq_b.size() ? mq_b[0] : -1, 16 + 8); end
    push(1, 0, 0, 2, c0);
    wait_mag(1, 2);
    total++; if (go_sw_b != 0) begin bad++; $display("FAIL shift0_sw_0 got %0d want 0", go_sw_b); end
    total++; if (mq_b.size() < 2 || mq_b[1] != 2 * 16) begin bad++; $display("FAIL shift0_mag_0 got %0d want %0d", mq_b.size() > 1 ? mq_b[1] : -1, 32); end
  endtask
  task automatic test_random;
    int c0, re, im, idx, sw;
    for (int i = 0; i < 16; i++) begin
      mq_a.delete();
      re = int'($urandom_range(0, 255)) - 128;
      im = int'($urandom_range(0, 255)) - 128;
      idx = int'($urandom_range(0, 127));
      sw = exp_sw(re, im, 7);
      push(0, re, im, idx, c0);
      wait_mag(0, 1);
      total++; if (go_sw_a != sw) begin bad++; $display("FAIL rand_sw re=%0d im=%0d got %0d want %0d", re, im, go_sw_a, sw); end
      total++; if (mq_a.size() == 0 || mq_a[0] != idx * 16 + isqrt(sw)) begin bad++; $display("FAIL rand_mag re=%0d im=%0d got %0d want %0d", re, im, mq_a.size() ? mq_a[0] : -1, idx * 16 + isqrt(sw)); end
    end
  endtask
  task automatic test_back_to_back;
    int expq[$];
    int acc, re, im, idx;
    mq_a.delete(); acc = 0;
    for (int k = 0; k < 200 && acc < 3; k++) begin
      @(negedge clk);
      re = int'($urandom_range(0, 255)) - 128;
      im = int'($urandom_range(0, 255)) - 128;
      idx = int'($urandom_range(0, 127));
      a_if.in_valid = 1'b1; a_if.in_re = 8'(re); a_if.in_im = 8'(im); a_if.in_idx = 7'(idx);
      if (a_if.in_ready) begin
        if (acc > 0) begin
          total++; if (a_if.mag_valid !== 1'b1) begin bad++; $display("FAIL b2b_accept_on_strobe n=%0d got mag_valid=%0b want 1", acc, a_if.mag_valid); end
        end
        expq.push_back(idx * 16 + isqrt(exp_sw(re, im, 7)));
        acc++;
      end
    end
    @(posedge clk);
    #1 a_if.in_valid = 1'b0;
    wait_mag(0, 3);
    repeat (3) @(negedge clk);
    total++; if (mq_a.size() != 3 || expq.size() != 3) begin bad++; $display("FAIL b2b_count got %0d strobes want 3", mq_a.size()); end
    for (int i = 0; i < 3 && i < mq_a.size() && i < expq.size(); i++) begin
      total++; if (mq_a[i] != expq[i]) begin bad++; $display("FAIL b2b_mag n=%0d got %0d want %0d", i, mq_a[i], expq[i]); end
    end
  endtask
  task automatic test_reset_midop;
    int c0;
    mq_a.delete();
    push(0, 100, 50, 5, c0);
    wait_mag(0, 1);
    push(0, 60, 70, 3, c0);
    repeat (12) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    total++; if (a_if.mag_out !== 4'd0 || a_if.mag_idx !== 7'd0) begin bad++; $display("FAIL rst_sqim_out got %0d/%0d want 0/0", a_if.mag_out, a_if.mag_idx); end
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_sqim_ready got %0b want 1", a_if.in_ready); end
    @(negedge clk);
    clr_n = 1'b1;
    mq_a.delete();
    repeat (30) @(negedge clk);
    total++; if (mq_a.size() != 0) begin bad++; $display("FAIL rst_sqim_nostrobe got %0d strobes want 0", mq_a.size()); end
    mute_a = 1'b1; go_n_a = 0;
    push(0, 100, 50, 9, c0);
    for (int k = 0; k < 100 && go_n_a == 0; k++) begin
      @(negedge clk);
      #1;
    end
    repeat (4) @(negedge clk);
    total++; if (a_if.sq_sw !== 8'd97) begin bad++; $display("FAIL wait_sw_held got %0d want 97", a_if.sq_sw); end
    #2 clr_n = 1'b0;
    #1;
    total++; if (a_if.sq_sw !== 8'd0 || a_if.sq_go !== 1'b0 || a_if.mag_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_out got sw=%0d go=%0b mv=%0b want 0/0/0", a_if.sq_sw, a_if.sq_go, a_if.mag_valid); end
    mute_a = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    mq_a.delete();
    push(0, 100, -50, 11, c0);
    wait_mag(0, 1);
    total++; if (mq_a.size() == 0 || mq_a[0] != 11 * 16 + 9 || go_sw_a != 97) begin bad++; $display("FAIL rst_recover got %0d sw=%0d want %0d sw=97", mq_a.size() ? mq_a[0] : -1, go_sw_a, 11 * 16 + 9); end
  endtask
  task automatic test_done_held;
    int c0;
    mq_a.delete();
    hold_a = 1'b1;
    push(0, 20, 30, 4, c0);
    wait_mag(0, 1);
    hold_a = 1'b0;
    total++; if (strobe_cyc_a - c0 != 19) begin bad++; $display("FAIL held_strobe_cycle got %0d want 19", strobe_cyc_a - c0); end
    repeat (10) @(negedge clk);
    total++; if (mq_a.size() != 1) begin bad++; $display("FAIL held_one_strobe got %0d want 1", mq_a.size()); end
    total++; if (mq_a.size() == 0 || mq_a[0] != 4 * 16 + 3) begin bad++; $display("FAIL held_mag got %0d want %0d", mq_a.size() ? mq_a[0] : -1, 4 * 16 + 3); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_shift0();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_done_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
